// File: rtl/ula_pkg.sv
// ula_pkg: ALU control codes and execute-stage FSM states, shared with the ALU control decoder.
package ula_pkg;
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MULTU = 4'b1000;
    typedef enum logic [1:0] {IDLE, DONE, MULT} state_t;
endpackage

// File: rtl/ula_multu.sv
// ula_multu: iterative shift-add unsigned multiplier, one bit of the multiplier per cycle.
module ula_multu #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0]   mcand, mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               run;
    logic [WIDTH:0]     upper;
    // product is the accumulator after this cycle's step, so the last step can be captured directly
    always_comb begin
        upper   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        product = (2*WIDTH)'({upper, acc[WIDTH-1:0]} >> 1);
        done    = run && &cnt;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            acc    <= product;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            run    <= !(&cnt);
        end
    end
endmodule

// File: rtl/ula_exec.sv
// ula_exec: registered execute-stage ALU; define ULA_EXEC_MULT_EN to add the 32-cycle multu path.
module ula_exec
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       inputALU,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] resultHi,
    output logic             zero,
    output logic             overflow,
    output logic             illegalOp
);
    state_t               state, nxt;
    logic                 is_mul, m_done, load, ill, ovf;
    logic [WIDTH-1:0]     sum, dif, alu, lo;
    logic [2*WIDTH-1:0]   prod;
`ifdef ULA_EXEC_MULT_EN
    assign is_mul = inputALU == ALU_MULTU;
    assign busy   = state == MULT;
    ula_multu #(.WIDTH(WIDTH)) u_multu (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start && state != MULT && is_mul),
        .a       (opA),
        .b       (opB),
        .done    (m_done),
        .product (prod)
    );
`else
    assign is_mul = 1'b0;
    assign busy   = 1'b0;
    assign m_done = 1'b0;
    assign prod   = '0;
`endif
    always_comb begin
        sum = opA + opB;
        dif = opA - opB;
        alu = inputALU == ALU_ADD ? sum :
              inputALU == ALU_SUB ? dif :
              inputALU == ALU_AND ? opA & opB :
              inputALU == ALU_OR  ? opA | opB :
              inputALU == ALU_SLT ? {{(WIDTH-1){1'b0}}, $signed(opA) < $signed(opB)} : '0;
        ill = !(inputALU inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT}) && !is_mul;
        ovf = inputALU == ALU_ADD ? (opA[WIDTH-1] == opB[WIDTH-1]) && (sum[WIDTH-1] != opA[WIDTH-1]) :
              inputALU == ALU_SUB ? (opA[WIDTH-1] != opB[WIDTH-1]) && (dif[WIDTH-1] != opA[WIDTH-1]) : 1'b0;
        lo  = state == MULT ? prod[WIDTH-1:0] : alu;
    end
    always_comb begin
        nxt  = IDLE;
        load = 1'b0;
        if (state == MULT) begin
            nxt  = m_done ? DONE : MULT;
            load = m_done;
        end else if (start) begin
            nxt  = is_mul ? MULT : DONE;
            load = !is_mul;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            result    <= '0;
            resultHi  <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            illegalOp <= 1'b0;
        end else begin
            state <= nxt;
            if (load) begin
                result    <= lo;
                resultHi  <= state == MULT ? prod[2*WIDTH-1:WIDTH] : '0;
                zero      <= lo == '0;
                overflow  <= state != MULT && ovf;
                illegalOp <= state != MULT && ill;
            end
        end
    end
    assign done = state == DONE;
endmodule

// File: tb/tb_ula_exec.sv
// tb_ula_exec: vector table plus multiply/abort sequences, checked through an expected-result queue.
module tb_ula_exec;
    localparam int W = 32;
    logic clk = 0, rst_n = 0, start = 0;
    logic [3:0] inputALU = 0;
    logic [W-1:0] opA = 0, opB = 0;
    logic busy, done, zero, overflow, illegalOp;
    logic [W-1:0] result, resultHi;
    int total = 0, bad = 0, cyc = 0;
    typedef struct {logic [3:0] c; logic [W-1:0] a, b, r; logic z, o, il;} vec_t;
    typedef struct {logic [W-1:0] r, h; logic z, o, il; int t;} exp_t;
    exp_t q[$];
    vec_t tv[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    ula_exec #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inputALU(inputALU), .opA(opA), .opB(opB),
        .busy(busy), .done(done), .result(result), .resultHi(resultHi), .zero(zero),
        .overflow(overflow), .illegalOp(illegalOp)
    );
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask
    task automatic chk_clear(input string n);
        chk({n, "_result"}, 64'(result), 0);
        chk({n, "_resultHi"}, 64'(resultHi), 0);
        chk({n, "_flags"}, {61'd0, zero, overflow, illegalOp}, 0);
        chk({n, "_done"}, 64'(done), 0);
        chk({n, "_busy"}, 64'(busy), 0);
    endtask
    task automatic send(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit exp_done, input int lat, input logic [W-1:0] r,
                        input logic [W-1:0] h, input logic z, input logic o, input logic il);
        start = 1; inputALU = c; opA = a; opB = b;
        if (exp_done) q.push_back('{r, h, z, o, il, cyc + lat});
    endtask
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want done=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("latency", 64'(cyc), 64'(e.t));
                chk("result", 64'(result), 64'(e.r));
                chk("resultHi", 64'(resultHi), 64'(e.h));
                chk("zero", 64'(zero), 64'(e.z));
                chk("overflow", 64'(overflow), 64'(e.o));
                chk("illegalOp", 64'(illegalOp), 64'(e.il));
            end
        end
    end
    initial begin
        int k;
        logic [W-1:0] ma[3], mb[3];
        logic [63:0] p;
        tv.push_back('{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0});
        tv.push_back('{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0});
        tv.push_back('{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0});
        tv.push_back('{4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 1'b0});
        tv.push_back('{4'b0001, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1'b0, 1'b0});
        tv.push_back('{4'b0101, 32'hDEADBEEF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1});
        tv.push_back('{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0});
        tv.push_back('{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0});
        tv.push_back('{4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0});
        tv.push_back('{4'b0110, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0});
        tv.push_back('{4'b0010, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b0});
        tv.push_back('{4'b0110, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0});
        tv.push_back('{4'b1111, 32'h0000FFFF, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 1'b1});
        tv.push_back('{4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0});
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_clear("reset");
        @(posedge clk); #1 rst_n = 1;
        foreach (tv[i]) begin
            @(posedge clk); #1;
            send(tv[i].c, tv[i].a, tv[i].b, 1, 1, tv[i].r, 0, tv[i].z, tv[i].o, tv[i].il);
        end
        @(posedge clk); #1 start = 0;
        repeat (3) @(posedge clk);
`ifdef ULA_EXEC_MULT_EN
        @(posedge clk); #1;
        k = cyc;
        send(4'b1000, 32'hFFFFFFFF, 32'h00000002, 1, 33, 32'hFFFFFFFE, 32'h00000001, 0, 0, 0);
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        chk("busy_first", 64'(busy), 1);
        repeat (4) @(posedge clk);
        #1 send(4'b0010, 32'h1, 32'h1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1 start = 0;
        while (cyc < k + 32) @(negedge clk);
        chk("busy_last", 64'(busy), 1);
        chk("no_early_done", 64'(done), 0);
        @(negedge clk);
        chk("busy_end", 64'(busy), 0);
        ma[0] = 32'h12345678; mb[0] = 32'h9ABCDEF0;
        ma[1] = 32'h00010000; mb[1] = 32'h00010000;
        ma[2] = 32'h00000000; mb[2] = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            p = {32'd0, ma[i]} * {32'd0, mb[i]};
            @(posedge clk); #1;
            send(4'b1000, ma[i], mb[i], 1, 33, p[31:0], p[63:32], p[31:0] == 0, 0, 0);
            @(posedge clk); #1 start = 0;
            repeat (34) @(posedge clk);
        end
        p = {32'd0, 32'hCAFEF00D} * {32'd0, 32'h0000BEEF};
        @(posedge clk); #1;
        send(4'b1000, 32'hCAFEF00D, 32'h0000BEEF, 1, 33, p[31:0], p[63:32], 0, 0, 0);
        @(posedge clk); #1 start = 0;
        repeat (34) @(posedge clk);
        #1 send(4'b1000, 32'h3, 32'h5, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1 start = 0;
        repeat (10) @(posedge clk);
        #1 rst_n = 0;
        @(negedge clk);
        chk_clear("abort");
        @(posedge clk); #1 rst_n = 1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("abort_idle_busy", 64'(busy), 0);
`else
        @(posedge clk); #1;
        send(4'b1000, 32'h7, 32'h3, 1, 1, 0, 0, 1, 0, 1);
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        chk("nomult_busy", 64'(busy), 0);
`endif
        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
        end
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
